// File: rtl/table_writer_pkg.sv
// Shared types and constants for the Aho-Corasick table loader.
package table_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Reserved current-state value that never matches a lookup.
    localparam logic [7:0] STATE_NONE = 8'hFF;

    // WR_DATA / goto entry field offsets.
    localparam int CUR_LSB  = 12;
    localparam int CHAR_LSB = 8;
    localparam int NEXT_LSB = 0;

    localparam logic GOTO_REC = 1'b0;
    localparam logic FAIL_REC = 1'b1;

endpackage

// File: rtl/table_writer_ram.sv
// Single write port, single registered read port array; contents are not reset.
module table_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_rdata <= '0;
        else          o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/table_writer.sv
// Goto/failure table loader: clears both tables, then fills them from a record stream.
// Optional DUP_CHECK_EN: a repeated (state, char) goto record overwrites the existing next state.
module table_writer
    import table_writer_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int STATE_W = 8,
    parameter int CHAR_W  = 4,
    parameter int AW      = $clog2(DEPTH),
    parameter int CW      = $clog2(DEPTH + 1),
    parameter int DW      = 2 * STATE_W + CHAR_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               WR_VALID,
    output logic               WR_READY,
    input  logic               WR_TYPE,
    input  logic               WR_LAST,
    input  logic [DW-1:0]      WR_DATA,
    input  logic [AW-1:0]      RD_ADDR,
    output logic [STATE_W-1:0] RD_CUR_STATE,
    output logic [CHAR_W-1:0]  RD_CHARA,
    output logic [STATE_W-1:0] RD_NEXT_STATE,
    output logic [STATE_W-1:0] RD_FAILURE,
    output logic [CW-1:0]      GOTO_COUNT,
    output logic               TABLE_VALID,
    output logic               BUSY,
    output logic               ERR
);

    state_t        r_state;
    logic [AW-1:0] r_clr_idx;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    logic [STATE_W-1:0] w_cur, w_next;
    logic [CHAR_W-1:0]  w_chr;
    logic               w_clear, w_acc, w_full, w_s_ok;
    logic               w_goto_ok, w_goto_app, w_fail_ok, w_rec_err;
    logic               w_dup_hit;
    logic [AW-1:0]      w_dup_idx;

    logic               w_g_we, w_f_we;
    logic [AW-1:0]      w_g_addr, w_f_addr;
    logic [DW-1:0]      w_g_wdata, w_g_rdata;
    logic [STATE_W-1:0] w_f_wdata;

    assign w_cur  = WR_DATA[CUR_LSB  +: STATE_W];
    assign w_chr  = WR_DATA[CHAR_LSB +: CHAR_W];
    assign w_next = WR_DATA[NEXT_LSB +: STATE_W];

    assign w_clear = (r_state == ST_CLEAR);
    // A START arriving with a record wins; the record is dropped.
    assign w_acc   = WR_VALID && (r_state == ST_LOAD) && !START;
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_s_ok  = (w_cur != '0) && (w_cur <= STATE_W'(DEPTH));

`ifdef DUP_CHECK_EN
    logic [STATE_W+CHAR_W-1:0] r_key [DEPTH];

    always_comb begin
        w_dup_hit = 1'b0;
        w_dup_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < r_cnt) && (r_key[i] == {w_cur, w_chr})) begin
                w_dup_hit = 1'b1;
                w_dup_idx = AW'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_goto_ok) r_key[w_g_addr] <= {w_cur, w_chr};
    end
`else
    assign w_dup_hit = 1'b0;
    assign w_dup_idx = '0;
`endif

    assign w_goto_ok  = w_acc && (WR_TYPE == GOTO_REC) && (w_cur != STATE_NONE)
                        && (w_dup_hit || !w_full);
    assign w_goto_app = w_goto_ok && !w_dup_hit;
    assign w_fail_ok  = w_acc && (WR_TYPE == FAIL_REC) && w_s_ok;
    assign w_rec_err  = w_acc && !(w_goto_ok || w_fail_ok);

    always_comb begin
        w_g_we    = w_clear || w_goto_ok;
        w_g_addr  = w_clear ? r_clr_idx : (w_dup_hit ? w_dup_idx : r_cnt[AW-1:0]);
        w_g_wdata = w_clear ? {STATE_NONE, CHAR_W'(0), STATE_W'(0)} : {w_cur, w_chr, w_next};
        w_f_we    = w_clear || w_fail_ok;
        w_f_addr  = w_clear ? r_clr_idx : AW'(w_cur - STATE_W'(1));
        w_f_wdata = w_clear ? '0 : w_next;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_clr_idx <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == AW'(DEPTH - 1)) r_state <= ST_LOAD;
                end
                default: begin
                    if (START) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= '0;
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                    end else if (r_state == ST_LOAD) begin
                        if (w_goto_app)        r_cnt   <= r_cnt + 1'b1;
                        if (w_rec_err)         r_err   <= 1'b1;
                        if (w_acc && WR_LAST)  r_state <= ST_DONE;
                    end
                end
            endcase
        end
    end

    assign WR_READY    = (r_state == ST_LOAD);
    assign BUSY        = (r_state == ST_CLEAR) || (r_state == ST_LOAD);
    assign TABLE_VALID = (r_state == ST_DONE);
    assign GOTO_COUNT  = r_cnt;
    assign ERR         = r_err;

    table_ram #(.W(DW), .DEPTH(DEPTH), .AW(AW)) u_goto (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_we    (w_g_we),
        .i_waddr (w_g_addr),
        .i_wdata (w_g_wdata),
        .i_raddr (RD_ADDR),
        .o_rdata (w_g_rdata)
    );

    table_ram #(.W(STATE_W), .DEPTH(DEPTH), .AW(AW)) u_fail (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_we    (w_f_we),
        .i_waddr (w_f_addr),
        .i_wdata (w_f_wdata),
        .i_raddr (RD_ADDR),
        .o_rdata (RD_FAILURE)
    );

    assign RD_CUR_STATE  = w_g_rdata[CUR_LSB  +: STATE_W];
    assign RD_CHARA      = w_g_rdata[CHAR_LSB +: CHAR_W];
    assign RD_NEXT_STATE = w_g_rdata[NEXT_LSB +: STATE_W];

endmodule

// File: tb/tb_table_writer.sv
// Directed, table-driven bench for table_writer (expectations follow DUP_CHECK_EN if defined).
module tb_table_writer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        WR_VALID = 1'b0;
    logic        WR_READY;
    logic        WR_TYPE = 1'b0;
    logic        WR_LAST = 1'b0;
    logic [19:0] WR_DATA = '0;
    logic [4:0]  RD_ADDR = '0;
    logic [7:0]  RD_CUR_STATE, RD_NEXT_STATE, RD_FAILURE;
    logic [3:0]  RD_CHARA;
    logic [5:0]  GOTO_COUNT;
    logic        TABLE_VALID, BUSY, ERR;

    int checks = 0;
    int errors = 0;

    table_writer dut (
        .CLK(CLK), .RST(RST), .START(START),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_TYPE(WR_TYPE),
        .WR_LAST(WR_LAST), .WR_DATA(WR_DATA), .RD_ADDR(RD_ADDR),
        .RD_CUR_STATE(RD_CUR_STATE), .RD_CHARA(RD_CHARA),
        .RD_NEXT_STATE(RD_NEXT_STATE), .RD_FAILURE(RD_FAILURE),
        .GOTO_COUNT(GOTO_COUNT), .TABLE_VALID(TABLE_VALID),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] cur;
        logic [3:0] chr;
        logic [7:0] nxt;
        logic [7:0] fail;
    } rd_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse START, then count cycles until WR_READY; optionally pulse START again mid-CLEAR.
    task automatic start_wait(input int pulse_at, output int n);
        @(negedge CLK) START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                chk("start_count", 32'(GOTO_COUNT), 0);
                chk("start_err", 32'(ERR), 0);
                chk("start_busy", 32'(BUSY), 1);
                chk("start_tv", 32'(TABLE_VALID), 0);
            end
            START = (n == pulse_at);
            if (WR_READY) break;
            n++;
        end
        START = 1'b0;
    endtask

    task automatic send(input logic typ, input logic last, input logic [19:0] data);
        @(negedge CLK);
        WR_VALID = 1'b1; WR_TYPE = typ; WR_LAST = last; WR_DATA = data;
        chk("send_ready", 32'(WR_READY), 1);
        @(posedge CLK);
        #1 WR_VALID = 1'b0; WR_LAST = 1'b0;
    endtask

    task automatic read_chk(input rd_vec_t v);
        @(negedge CLK) RD_ADDR = v.addr;
        @(negedge CLK);
        chk($sformatf("rd_cur[%0d]", v.addr), 32'(RD_CUR_STATE), 32'(v.cur));
        chk($sformatf("rd_chr[%0d]", v.addr), 32'(RD_CHARA), 32'(v.chr));
        chk($sformatf("rd_nxt[%0d]", v.addr), 32'(RD_NEXT_STATE), 32'(v.nxt));
        chk($sformatf("rd_fail[%0d]", v.addr), 32'(RD_FAILURE), 32'(v.fail));
    endtask

    function automatic rd_vec_t mk(input int a, input int c, input int ch, input int nx, input int f);
        rd_vec_t v;
        v.addr = 5'(a); v.cur = 8'(c); v.chr = 4'(ch); v.nxt = 8'(nx); v.fail = 8'(f);
        return v;
    endfunction

    rd_vec_t vecs[6];
    int n;

    initial begin
        vecs[0] = mk(0, 0,     1, 1, 0);
        vecs[1] = mk(1, 1,     2, 2, 0);
        vecs[2] = mk(2, 8'hFF, 0, 0, 7);
        vecs[3] = mk(3, 8'hFF, 0, 0, 0);
        vecs[4] = mk(31, 8'hFF, 0, 0, 0);
        vecs[5] = mk(30, 8'hFF, 0, 0, 0);

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(WR_READY), 0);
        chk("rst_count", 32'(GOTO_COUNT), 0);
        chk("rst_tv", 32'(TABLE_VALID), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_rd", {RD_CUR_STATE, RD_CHARA, RD_NEXT_STATE, RD_FAILURE[3:0]}, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_busy", 32'(BUSY), 0);

        // clear timing, with an ignored START pulse mid-clear
        start_wait(10, n);
        chk("clear_len", 32'(n), 32);
        for (int a = 0; a < 32; a++) read_chk(mk(a, 8'hFF, 0, 0, 0));

        // basic load
        send(1'b0, 1'b0, {8'd0, 4'h1, 8'd1});
        send(1'b0, 1'b0, {8'd1, 4'h2, 8'd2});
        send(1'b1, 1'b0, {8'd3, 4'h0, 8'd7});
        send(1'b1, 1'b1, {8'd2, 4'h0, 8'd0});
        @(negedge CLK);
        chk("load_count", 32'(GOTO_COUNT), 2);
        chk("load_tv", 32'(TABLE_VALID), 1);
        chk("load_busy", 32'(BUSY), 0);
        chk("load_err", 32'(ERR), 0);
        chk("done_ready", 32'(WR_READY), 0);
        foreach (vecs[i]) read_chk(vecs[i]);

        // overflow: 33rd goto record dropped
        start_wait(-1, n);
        chk("clear_len2", 32'(n), 32);
        for (int i = 0; i < 33; i++) send(1'b0, i == 32, {8'(i), 4'h3, 8'(i + 1)});
        @(negedge CLK);
        chk("ovf_err", 32'(ERR), 1);
        chk("ovf_count", 32'(GOTO_COUNT), 32);
        chk("ovf_tv", 32'(TABLE_VALID), 1);
        read_chk(mk(31, 31, 3, 32, 0));
        read_chk(mk(0, 0, 3, 1, 0));

        // bad failure indices and sentinel goto
        start_wait(-1, n);
        send(1'b0, 1'b0, {8'd5, 4'h6, 8'd6});
        @(negedge CLK) chk("err_clean", 32'(ERR), 0);
        send(1'b1, 1'b0, {8'd0, 4'h0, 8'd9});
        @(negedge CLK) chk("err_s0", 32'(ERR), 1);
        send(1'b1, 1'b0, {8'd33, 4'h0, 8'd9});
        send(1'b0, 1'b0, {8'hFF, 4'h1, 8'd3});
        send(1'b1, 1'b1, {8'd32, 4'h0, 8'd4});
        @(negedge CLK);
        chk("bad_count", 32'(GOTO_COUNT), 1);
        chk("bad_tv", 32'(TABLE_VALID), 1);
        read_chk(mk(31, 8'hFF, 0, 0, 4));
        read_chk(mk(0, 5, 6, 6, 0));
        read_chk(mk(1, 8'hFF, 0, 0, 0));

        // restart mid-load
        start_wait(-1, n);
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0, {8'(10 + i), 4'h4, 8'(20 + i)});
        send(1'b1, 1'b0, {8'd0, 4'h0, 8'd1});
        @(negedge CLK);
        chk("mid_count", 32'(GOTO_COUNT), 5);
        chk("mid_err", 32'(ERR), 1);
        start_wait(-1, n);
        chk("clear_len3", 32'(n), 32);
        read_chk(mk(4, 8'hFF, 0, 0, 0));

        // duplicate (state, char)
        send(1'b0, 1'b0, {8'd3, 4'h5, 8'd7});
        send(1'b0, 1'b1, {8'd3, 4'h5, 8'd9});
        @(negedge CLK);
        chk("dup_err", 32'(ERR), 0);
`ifdef DUP_CHECK_EN
        chk("dup_count", 32'(GOTO_COUNT), 1);
        read_chk(mk(0, 3, 5, 9, 0));
        read_chk(mk(1, 8'hFF, 0, 0, 0));
`else
        chk("dup_count", 32'(GOTO_COUNT), 2);
        read_chk(mk(0, 3, 5, 7, 0));
        read_chk(mk(1, 3, 5, 9, 0));
`endif

        // reset during CLEAR returns to IDLE and stays there
        @(negedge CLK) START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("mrst_busy", 32'(BUSY), 0);
        chk("mrst_count", 32'(GOTO_COUNT), 0);
        chk("mrst_tv", 32'(TABLE_VALID), 0);
        @(negedge CLK) RST = 1'b1;
        repeat (40) @(negedge CLK);
        chk("mrst_idle_busy", 32'(BUSY), 0);
        chk("mrst_idle_ready", 32'(WR_READY), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/table_writer.md
# table_writer

Loader for the Aho-Corasick goto and failure tables consumed by the state-transition lookup logic. It accepts a stream of goto and failure records over a valid/ready handshake, clears and fills the on-chip tables, and exposes a registered read port plus a table-valid flag. This makes pattern sets loadable at run time instead of from fixed initialisation files.

## Interface
- DEPTH, 32, entries per table (goto and failure)
- STATE_W, 8, state number width
- CHAR_W, 4, input character width

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- START  in  1  one-cycle pulse: clear tables and begin a load
- WR_VALID  in  1  record present
- WR_READY  out  1  writer accepts record this cycle
- WR_TYPE  in  1  0 = goto record, 1 = failure record
- WR_LAST  in  1  final record of the load
- WR_DATA  in  20  goto: [19:12] current state, [11:8] char, [7:0] next state; failure: [19:12] state S, [7:0] failure state, [11:8] ignored
- RD_ADDR  in  5  lookup index
- RD_CUR_STATE  out  STATE_W  goto current state at RD_ADDR
- RD_CHARA  out  CHAR_W  goto character at RD_ADDR
- RD_NEXT_STATE  out  STATE_W  goto next state at RD_ADDR
- RD_FAILURE  out  STATE_W  failure state stored at RD_ADDR (i.e. for state RD_ADDR+1)
- GOTO_COUNT  out  6  number of valid goto entries
- TABLE_VALID  out  1  tables complete and consistent
- BUSY  out  1  clear or load in progress
- ERR  out  1  sticky error since last START

## Operation
- FSM states: IDLE, CLEAR, LOAD, DONE.
- IDLE to CLEAR on START. DONE to CLEAR on START.
- CLEAR: walks index 0..DEPTH-1, one entry per cycle. Each goto entry is written to current state 8'hFF (a reserved, never-matching sentinel), char 0 and next state 0. Each failure entry is written to 0. After index DEPTH-1 the FSM moves to LOAD.
- LOAD: WR_READY=1. A record is accepted on WR_VALID & WR_READY.
  - Goto record: written at index GOTO_COUNT, then GOTO_COUNT increments.
  - Failure record: written at index S-1.
- Accepting a record with WR_LAST=1 moves the FSM to DONE. TABLE_VALID=1 only in DONE.
- Errors (ERR set, record dropped, handshake still completes):
  - goto record with GOTO_COUNT==DEPTH
  - failure record with S==0 or S>DEPTH
  - goto record whose current state is 8'hFF
- START clears ERR, GOTO_COUNT and TABLE_VALID in the cycle after it is sampled.
- START in LOAD or DONE restarts at CLEAR index 0. START during CLEAR is ignored.
- A WR_LAST record that is itself an error still ends the load.
- Only START leaves DONE. Records arriving in IDLE, CLEAR or DONE see WR_READY=0.

## Timing
- Reset values: WR_READY=0, GOTO_COUNT=0, TABLE_VALID=0, BUSY=0, ERR=0, all RD_* outputs 0, FSM in IDLE.
- Table memories are not reset; their contents are meaningless until CLEAR completes.
- START sampled at edge t puts the FSM in CLEAR from t+1. CLEAR lasts exactly DEPTH cycles. WR_READY rises at t+1+DEPTH.
- BUSY=1 in CLEAR and LOAD.
- An accepted record is visible on the read port for a read issued in the next cycle.
- Read port latency: RD_ADDR sampled at edge t, data valid after edge t+1 (registered). Reads are allowed in any state. No read-during-write bypass is required because TABLE_VALID gates use.
- Reset asserted mid-operation: returns to IDLE immediately with reset output values. A new START is required.

## Configuration
- DUP_CHECK_EN defined: a goto record whose (current state, char) pair matches an existing valid entry (index < GOTO_COUNT) overwrites that entry's next state. GOTO_COUNT is unchanged and ERR is not set. The compare against all DEPTH entries is combinational and single-cycle.
- DUP_CHECK_EN undefined: every goto record appends, duplicates included.

## Structure
- Shared package holds:
  - FSM state encoding
  - the sentinel STATE_NONE = 8'hFF
  - WR_DATA field offsets
  - record type constants GOTO_REC and FAIL_REC
- One sub-module, table_ram: a single-write-port, single-registered-read-port array, instanced once for the goto table (20-bit entries) and once for the failure table (8-bit entries).

## Test plan
- Reset, then START; wait 32 cycles -> WR_READY rises at cycle 33. Reading every index returns RD_CUR_STATE=8'hFF, RD_FAILURE=0.
- Load goto {0,4'h1,1}, {1,4'h2,2}, then failure S=2 -> 0 with WR_LAST -> GOTO_COUNT=2, TABLE_VALID=1. RD_ADDR=1 gives cur 1, char 2, next 2. RD_FAILURE at index 1 is 0.
- 33 goto records -> the 33rd is dropped, ERR=1, GOTO_COUNT=32, handshake completes.
- Failure record S=0, then S=33 -> ERR=1, failure table unchanged.
- START mid-LOAD with 5 entries written -> CLEAR restarts, GOTO_COUNT=0, ERR=0, index 4 reads 8'hFF afterwards.
- DUP_CHECK_EN: {3,4'h5,7} then {3,4'h5,9} -> GOTO_COUNT=1, next state 9. Without the macro: GOTO_COUNT=2.
